lifo_arb: RTL and testbench
===========================

LIFO_ARB -- requirements
Module: lifo_arb

Interface
REQ-001 Parameter DataWidth, default 32, width of stack words and all data ports.
REQ-002 Parameter Depth, default 16, stack capacity in words; fixed to match 4-bit LIFO pointer.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 REQA / REQB  input  1 each  requester A / B operation request, held high until ACK seen.
REQ-006 WEA / WEB  input  1 each  1 = push, 0 = pop; qualified by REQx.
REQ-007 WDATAA / WDATAB  input  DataWidth each  push data; qualified by REQx & WEx.
REQ-008 ACKA / ACKB  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 ERRA / ERRB  output  1 each  valid with ACKx; 1 = op rejected (push when full, pop when empty).
REQ-010 RDATA  output  DataWidth  popped word, shared; valid in the ACK cycle of an accepted pop.
REQ-011 COUNT  output  5  current stack occupancy, 0..16.
REQ-012 FULL / EMPTY  output  1 each  COUNT==16 / COUNT==0.
REQ-013 L_PUSH / L_POP  output  1 each  stack command strobes, registered.
REQ-014 L_DTI  output  DataWidth  stack write data, registered.
REQ-015 L_DTO  input  DataWidth  stack top-of-stack data, registered inside stack (one-cycle read latency).

Function
REQ-016 FSM states IDLE, OP, SETTLE; one operation in flight at a time.
REQ-017 IDLE: if any REQx high, grant one requester, register command, go OP; else stay IDLE.
REQ-018 Arbitration round-robin: single request wins; both high -> requester not granted last wins; after reset A has priority.
REQ-019 Accepted push (grant, WEx=1, COUNT<16): L_PUSH=1 and L_DTI=WDATAx during OP; COUNT+1 at end of OP.
REQ-020 Accepted pop (grant, WEx=0, COUNT>0): RDATA<=L_DTO at grant edge; L_POP=1 during OP; COUNT-1 at end of OP.
REQ-021 ACKx=1 for exactly the OP cycle of the granted requester; ERRx=0 for accepted ops.
REQ-022 Accepted ops: OP -> SETTLE -> IDLE; SETTLE allows L_DTO to reflect new top before next grant.
REQ-023 Rejected op (push at FULL, pop at EMPTY): OP cycle with ACKx=1, ERRx=1, L_PUSH=L_POP=0, COUNT and RDATA unchanged; OP -> IDLE.
REQ-024 L_PUSH and L_POP never high together; never high outside OP.
REQ-025 Latency REQ sampled in IDLE -> ACK 1 cycle; accepted throughput one op per 3 cycles, rejected one per 2.
REQ-026 REQx/WEx/WDATAx sampled only at grant edge; changes while in OP/SETTLE ignored.
REQ-027 COUNT never wraps: saturates by rejection rule, never exceeds 16 or drops below 0.
REQ-028 ACKA and ACKB never high in the same cycle.

Reset
REQ-029 RESET low forces state IDLE, COUNT=0, EMPTY=1, FULL=0, ACKx=0, ERRx=0, L_PUSH=L_POP=0, L_DTI=0, RDATA=0, round-robin pointer favouring A.
REQ-030 Reset mid-operation abandons the op with no ACK; stack shares same RESET so its pointer realigns with COUNT=0.
REQ-031 First grant possible on the first rising edge after RESET deasserts.

Verification
REQ-032 A pushes 0x11, 0x22, 0x33; A pops three times -> RDATA 0x33, 0x22, 0x11 with ERRA=0; COUNT 3 then 0, EMPTY=1.
REQ-033 Pop from empty by B -> ACKB one cycle with ERRB=1, no L_POP, COUNT stays 0.
REQ-034 17 pushes of 1..17 -> first 16 ACK with ERR=0, FULL=1 after 16th; 17th ERR=1, no L_PUSH; next pop returns 16.
REQ-035 REQA and REQB both held continuously with pushes -> grants alternate A,B,A,B starting with A; each grant separated by 3 cycles.
REQ-036 A push then B pop in consecutive grants -> B's RDATA equals A's pushed word (SETTLE honoured, no stale top).
REQ-037 RESET asserted during OP of a push -> no ACK, COUNT=0 after reset; subsequent pop -> ERR=1.

Source files
------------

// File: rtl/lifo_arb_if.sv
// Requester-side bus of the LIFO arbiter: two request/ack channels
// sharing one pop-data return.
interface lifo_arb_if #(
  parameter int DataWidth = 32
);
  logic                 REQA;
  logic                 REQB;
  logic                 WEA;
  logic                 WEB;
  logic [DataWidth-1:0] WDATAA;
  logic [DataWidth-1:0] WDATAB;
  logic                 ACKA;
  logic                 ACKB;
  logic                 ERRA;
  logic                 ERRB;
  logic [DataWidth-1:0] RDATA;

  modport master (
    output REQA, REQB, WEA, WEB, WDATAA, WDATAB,
    input  ACKA, ACKB, ERRA, ERRB, RDATA
  );

  modport slave (
    input  REQA, REQB, WEA, WEB, WDATAA, WDATAB,
    output ACKA, ACKB, ERRA, ERRB, RDATA
  );
endinterface

// File: rtl/lifo_arb.sv
// Two-port round-robin front end for an external registered LIFO.
// One op in flight; accepted ops settle a cycle so the top refreshes.
module lifo_arb #(
  parameter int DataWidth = 32,
  parameter int Depth     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  lifo_arb_if.slave            bus,
  output logic [4:0]           COUNT,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 L_PUSH,
  output logic                 L_POP,
  output logic [DataWidth-1:0] L_DTI,
  input  logic [DataWidth-1:0] L_DTO
);

  localparam logic [4:0] Cap = 5'(Depth);

  typedef enum logic [1:0] {
    IDLE,
    OP,
    SETTLE
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_b_q, prio_b_d;
  logic [4:0]           count_q, count_d;
  logic                 acka_q, acka_d;
  logic                 ackb_q, ackb_d;
  logic                 erra_q, erra_d;
  logic                 errb_q, errb_d;
  logic                 push_q, push_d;
  logic                 pop_q, pop_d;
  logic [DataWidth-1:0] dti_q, dti_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic                 pick_b;
  logic                 we;
  logic                 ok;
  logic [DataWidth-1:0] wd;

  always_comb begin
    state_d  = state_q;
    prio_b_d = prio_b_q;
    count_d  = count_q;
    acka_d   = 1'b0;
    ackb_d   = 1'b0;
    erra_d   = 1'b0;
    errb_d   = 1'b0;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    dti_d    = dti_q;
    rdata_d  = rdata_q;
    pick_b   = 1'b0;
    we       = 1'b0;
    ok       = 1'b0;
    wd       = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.REQA || bus.REQB) begin
          pick_b   = bus.REQB && (!bus.REQA || prio_b_q);
          we       = pick_b ? bus.WEB : bus.WEA;
          wd       = pick_b ? bus.WDATAB : bus.WDATAA;
          ok       = we ? (count_q != Cap) : (count_q != 5'd0);
          acka_d   = !pick_b;
          ackb_d   = pick_b;
          erra_d   = !pick_b && !ok;
          errb_d   = pick_b && !ok;
          push_d   = ok && we;
          pop_d    = ok && !we;
          // the stack top is registered, so it is captured at grant
          if (ok && we) dti_d = wd;
          if (ok && !we) rdata_d = L_DTO;
          prio_b_d = !pick_b;
          state_d  = OP;
        end
      end
      OP: begin
        unique case (1'b1)
          push_q:  count_d = count_q + 5'd1;
          pop_q:   count_d = count_q - 5'd1;
          default: count_d = count_q;
        endcase
        state_d = (push_q || pop_q) ? SETTLE : IDLE;
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      prio_b_q <= 1'b0;
      count_q  <= '0;
      acka_q   <= 1'b0;
      ackb_q   <= 1'b0;
      erra_q   <= 1'b0;
      errb_q   <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      dti_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_b_q <= prio_b_d;
      count_q  <= count_d;
      acka_q   <= acka_d;
      ackb_q   <= ackb_d;
      erra_q   <= erra_d;
      errb_q   <= errb_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      dti_q    <= dti_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.ACKA  = acka_q;
  assign bus.ACKB  = ackb_q;
  assign bus.ERRA  = erra_q;
  assign bus.ERRB  = errb_q;
  assign bus.RDATA = rdata_q;
  assign COUNT     = count_q;
  assign FULL      = (count_q == Cap);
  assign EMPTY     = (count_q == 5'd0);
  assign L_PUSH    = push_q;
  assign L_POP     = pop_q;
  assign L_DTI     = dti_q;

endmodule

// File: tb/tb_lifo_arb.sv
// Bench for lifo_arb: directed scenarios plus random two-requester traffic
// against a queue-based model, with a registered stack attached.
module tb_lifo_arb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  COUNT;
  logic        FULL, EMPTY, L_PUSH, L_POP;
  logic [31:0] L_DTI, L_DTO;

  lifo_arb_if #(.DataWidth(32)) bus ();

  lifo_arb #(.DataWidth(32), .Depth(16)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (bus),
    .COUNT  (COUNT),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .L_PUSH (L_PUSH),
    .L_POP  (L_POP),
    .L_DTI  (L_DTI),
    .L_DTO  (L_DTO)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // external stack: top-of-stack output is registered
  logic [31:0] smem [16];
  int          sp;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sp    <= 0;
      L_DTO <= '0;
    end else begin
      L_DTO <= (sp > 0) ? smem[sp-1] : 32'h0;
      if (L_PUSH && sp < 16) begin
        smem[sp] <= L_DTI;
        sp       <= sp + 1;
      end else if (L_POP && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mq[$];
  logic [31:0] m_rdata;
  bit          last_b;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdata = '0;
    last_b  = 1'b1;
  endtask

  task automatic model_op(input bit b, input bit we, input logic [31:0] d,
                          output bit err, output bit acc);
    if (we) begin
      acc = (mq.size() < 16);
      if (acc) mq.push_back(d);
    end else begin
      acc = (mq.size() > 0);
      if (acc) m_rdata = mq.pop_back();
    end
    err    = !acc;
    last_b = b;
  endtask

  task automatic clear_reqs();
    bus.REQA = 0; bus.REQB = 0;
    bus.WEA = 0; bus.WEB = 0;
    bus.WDATAA = '0; bus.WDATAB = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_acks", {bus.ACKA, bus.ACKB}, 0);
    chk("rst_errs", {bus.ERRA, bus.ERRB}, 0);
    chk("rst_strobes", {L_PUSH, L_POP}, 0);
    chk("rst_l_dti", L_DTI, 0);
    chk("rst_rdata", bus.RDATA, 0);
    RESET = 1'b1;
  endtask

  // single requester op, starting and ending at a negedge with the DUT idle
  task automatic op(input bit b, input bit we, input logic [31:0] d);
    bit e, acc;
    int lat;
    if (b) begin
      bus.REQB = 1; bus.WEB = we; bus.WDATAB = d;
    end else begin
      bus.REQA = 1; bus.WEA = we; bus.WDATAA = d;
    end
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!(b ? bus.ACKB : bus.ACKA) && lat < 8);
    chk("ack_latency", lat, 1);
    chk("count_in_op", COUNT, mq.size());
    model_op(b, we, d, e, acc);
    chk("ack_other", b ? bus.ACKA : bus.ACKB, 0);
    chk("err", b ? bus.ERRB : bus.ERRA, e);
    chk("l_push", L_PUSH, acc && we);
    chk("l_pop", L_POP, acc && !we);
    chk("rdata", bus.RDATA, m_rdata);
    if (acc && we) chk("l_dti", L_DTI, d);
    if (b) bus.REQB = 0; else bus.REQA = 0;
    @(negedge CLK);
    chk("ack_gone", {bus.ACKA, bus.ACKB}, 0);
    chk("strobes_gone", {L_PUSH, L_POP}, 0);
    chk("count", COUNT, mq.size());
    chk("full", FULL, mq.size() == 16);
    chk("empty", EMPTY, mq.size() == 0);
    if (acc) @(negedge CLK);
  endtask

  initial begin
    bit e, acc, pend_a, pend_b, pb, ob;
    int last_cyc, w, push_pct, stall;

    do_reset();

    // LIFO order
    op(0, 1, 32'h11);
    op(0, 1, 32'h22);
    op(0, 1, 32'h33);
    chk("count_three", COUNT, 3);
    op(0, 0, 0);
    op(0, 0, 0);
    op(0, 0, 0);
    chk("empty_after_pops", EMPTY, 1);

    // pop at empty by B
    op(1, 0, 0);

    // fill to capacity, then overflow attempt, then pop
    for (int i = 1; i <= 17; i++) op(0, 1, 32'(i));
    chk("full_after_fill", FULL, 1);
    op(1, 0, 0);
    chk("pop_after_full", bus.RDATA, 32'd16);

    // push then immediate pop by the other side
    do_reset();
    op(0, 1, 32'h5A5A_0001);
    op(1, 0, 0);
    op(0, 1, 32'hAA);
    op(1, 1, 32'hBB);
    op(0, 0, 0);
    op(1, 0, 0);

    // both requesters held with pushes: A,B,A,B with a 3-cycle spacing
    do_reset();
    bus.REQA = 1; bus.WEA = 1; bus.WDATAA = $urandom;
    bus.REQB = 1; bus.WEB = 1; bus.WDATAB = $urandom;
    last_cyc = 0;
    for (int g = 0; g < 6; g++) begin
      w = 0;
      do begin
        @(negedge CLK);
        w++;
      end while (!(bus.ACKA || bus.ACKB) && w < 10);
      if (g == 0) chk("alt_first_latency", w, 1);
      else chk("alt_gap", cyc - last_cyc, 3);
      last_cyc = cyc;
      chk("alt_grant", bus.ACKB, (g % 2) == 1);
      ob = bus.ACKB;
      model_op(ob, 1'b1, ob ? bus.WDATAB : bus.WDATAA, e, acc);
      chk("alt_err", ob ? bus.ERRB : bus.ERRA, e);
      chk("alt_l_dti", L_DTI, mq[mq.size()-1]);
      bus.WDATAA = $urandom;
      bus.WDATAB = $urandom;
    end
    clear_reqs();
    repeat (2) @(negedge CLK);
    chk("alt_count", COUNT, 6);

    // reset during a push's OP cycle
    do_reset();
    bus.REQA = 1; bus.WEA = 1; bus.WDATAA = 32'h77;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_ack", bus.ACKA, 0);
    chk("midrst_push", L_PUSH, 0);
    chk("midrst_count", COUNT, 0);
    clear_reqs();
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    op(0, 0, 0);

    // random two-requester traffic
    pend_a = 0;
    pend_b = 0;
    stall  = 0;
    for (int c = 0; c < 3000; c++) begin
      push_pct = (c < 1000) ? 75 : (c < 2000) ? 25 : 50;
      @(negedge CLK);
      chk("rnd_count", COUNT, mq.size());
      chk("rnd_full", FULL, mq.size() == 16);
      chk("rnd_empty", EMPTY, mq.size() == 0);
      chk("rnd_ack_excl", bus.ACKA && bus.ACKB, 0);
      chk("rnd_strobe_excl", L_PUSH && L_POP, 0);
      if (bus.ACKA || bus.ACKB) begin
        stall = 0;
        ob = bus.ACKB;
        pb = (pend_a && pend_b) ? !last_b : pend_b;
        chk("rnd_pending", pend_a || pend_b, 1);
        chk("rnd_grant", ob, pb);
        model_op(ob, ob ? bus.WEB : bus.WEA,
                 ob ? bus.WDATAB : bus.WDATAA, e, acc);
        chk("rnd_err", ob ? bus.ERRB : bus.ERRA, e);
        chk("rnd_l_push", L_PUSH, acc && (ob ? bus.WEB : bus.WEA));
        chk("rnd_l_pop", L_POP, acc && !(ob ? bus.WEB : bus.WEA));
        chk("rnd_rdata", bus.RDATA, m_rdata);
        if (ob) begin
          bus.REQB = 0;
          pend_b = 0;
        end else begin
          bus.REQA = 0;
          pend_a = 0;
        end
      end else begin
        chk("rnd_strobe_idle", L_PUSH || L_POP, 0);
        if (pend_a || pend_b) stall++;
        if (stall > 8) begin
          chk("rnd_timeout", 0, 1);
          clear_reqs();
          pend_a = 0;
          pend_b = 0;
          stall  = 0;
        end
      end
      if (!pend_a && $urandom_range(0, 2) == 0) begin
        bus.REQA = 1;
        bus.WEA = ($urandom_range(0, 99) < push_pct);
        bus.WDATAA = $urandom;
        pend_a = 1;
      end
      if (!pend_b && $urandom_range(0, 2) == 0) begin
        bus.REQB = 1;
        bus.WEB = ($urandom_range(0, 99) < push_pct);
        bus.WDATAB = $urandom;
        pend_b = 1;
      end
    end
    clear_reqs();
    repeat (4) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
